// File: rtl/decode_stage_pkg.sv
// Types shared by the decode/operand-fetch stage and its register file.
package decode_stage_pkg;

   typedef enum logic [6:0] {
      OP     = 7'b0110011,
      OP_IMM = 7'b0010011
   } opcode_e;

   typedef enum logic [6:0] {
      F7_BASE = 7'h00,
      F7_NEG  = 7'h20
   } alu_funct7_e;

   typedef enum logic [2:0] {
      F3_ADD  = 3'd0,
      F3_SLL  = 3'd1,
      F3_SLT  = 3'd2,
      F3_SLTU = 3'd3,
      F3_XOR  = 3'd4,
      F3_SR   = 3'd5,
      F3_OR   = 3'd6,
      F3_AND  = 3'd7
   } alu_funct3_e;

   // rd keeps the full 5-bit instruction field; the top slices it to REG_AW.
   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      alu_funct7_e funct7;
      alu_funct3_e funct3;
      logic [4:0]  rd;
   } dec_op_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational write-first read ports,
// one synchronous write port, x0 reads as zero.
module decode_stage_regfile
   import decode_stage_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [31:0]       rdata_a,
   output logic [31:0]       rdata_b,
   input  logic              wen,
   input  logic [REG_AW-1:0] waddr,
   input  logic [31:0]       wdata
);

   logic [31:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (wen && waddr != '0) begin
         mem[waddr] <= wdata;
      end
   end

   // Same-cycle writeback is forwarded so a waking instruction sees fresh data.
   always_comb begin
      rdata_a = mem[raddr_a];
      rdata_b = mem[raddr_b];
      if (wen && waddr == raddr_a) rdata_a = wdata;
      if (wen && waddr == raddr_b) rdata_b = wdata;
      if (raddr_a == '0) rdata_a = '0;
      if (raddr_b == '0) rdata_b = '0;
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode + operand fetch with RAW scoreboard in front of the ALU.
// Optional DECODE_PERF_EN adds issue/stall counters.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter  int NUM_REGS = 32,
   localparam int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       instr_i,
   input  logic              instr_valid_i,
   output logic              instr_ready_o,
   output logic [31:0]       operand_1_o,
   output logic [31:0]       operand_2_o,
   output alu_funct7_e       funct7_o,
   output alu_funct3_e       funct3_o,
   output logic [REG_AW-1:0] rd_o,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   input  logic              wb_en_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [31:0]       wb_data_i,
   output logic              illegal_o
`ifdef DECODE_PERF_EN
   ,
   output logic [31:0]       issue_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   logic [6:0]        opcode, f7;
   logic [2:0]        f3;
   logic [REG_AW-1:0] rs1, rs2;
   logic [4:0]        rd_f;
   logic              is_r, is_i, legal, hazard, free, fire, issue;
   logic [31:0]       rs1_val, rs2_val;
   logic [NUM_REGS-1:0] busy, busy_nxt;
   dec_op_t           dec, op_q;

   assign opcode = instr_i[6:0];
   assign rd_f   = instr_i[11:7];
   assign f3     = instr_i[14:12];
   assign rs1    = instr_i[15+:REG_AW];
   assign rs2    = instr_i[20+:REG_AW];
   assign f7     = instr_i[31:25];

   assign is_r  = (opcode == OP);
   assign is_i  = (opcode == OP_IMM);
   assign legal = is_i || (is_r && (f7 == F7_BASE || f7 == F7_NEG));

   decode_stage_regfile #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_rf (
      .clk(clk_i), .rst(rst_i),
      .raddr_a(rs1), .raddr_b(rs2),
      .rdata_a(rs1_val), .rdata_b(rs2_val),
      .wen(wb_en_i), .waddr(wb_rd_i), .wdata(wb_data_i)
   );

   // A writeback landing this cycle releases its register immediately.
   assign hazard = (rs1 != '0 && busy[rs1] && !(wb_en_i && wb_rd_i == rs1)) ||
                   (is_r && rs2 != '0 && busy[rs2] && !(wb_en_i && wb_rd_i == rs2));
   assign free          = !ex_valid_o || ex_ready_i;
   assign instr_ready_o = free && !hazard && !rst_i;
   assign fire          = instr_valid_i && instr_ready_o;
   assign issue         = fire && legal;

   always_comb begin
      dec        = '0;
      dec.op1    = rs1_val;
      dec.op2    = is_r ? rs2_val : {{20{instr_i[31]}}, instr_i[31:20]};
      dec.funct7 = is_r ? alu_funct7_e'(f7) : F7_BASE;
      dec.funct3 = alu_funct3_e'(f3);
      dec.rd     = rd_f;
   end

   // Set after clear so a same-cycle reissue of rd stays busy.
   always_comb begin
      busy_nxt = busy;
      if (wb_en_i) busy_nxt[wb_rd_i] = 1'b0;
      if (issue && rd_f[REG_AW-1:0] != '0) busy_nxt[rd_f[REG_AW-1:0]] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_o <= 1'b0;
         op_q       <= '0;
         illegal_o  <= 1'b0;
         busy       <= '0;
      end else begin
         illegal_o <= fire && !legal;
         busy      <= busy_nxt;
         if (free) begin
            ex_valid_o <= issue;
            if (issue) op_q <= dec;
         end
      end
   end

   assign operand_1_o = op_q.op1;
   assign operand_2_o = op_q.op2;
   assign funct7_o    = op_q.funct7;
   assign funct3_o    = op_q.funct3;
   assign rd_o        = op_q.rd[REG_AW-1:0];

`ifdef DECODE_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issue_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (issue) issue_cnt_o <= issue_cnt_o + 32'd1;
         if (instr_valid_i && !instr_ready_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
